// File: rtl/ym_psg_pkg.sv
// Shared definitions for the TurboSound PSG bus responder:
// bus mode codes, FSM states and per-register width masks.
package ym_psg_pkg;

  typedef enum logic [1:0] {
    MODE_IDLE  = 2'b00,
    MODE_READ  = 2'b01,
    MODE_WRITE = 2'b10,
    MODE_LATCH = 2'b11
  } bus_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ARMING = 2'd1,
    ST_ACTIVE = 2'd2
  } bus_state_e;

  localparam logic [4:0] TS_SELECT     = 5'b11111;
  localparam logic [3:0] ENV_SHAPE_REG = 4'd13;

  // Index 15 first: {R15, R14, ..., R1, R0}
  localparam logic [15:0][7:0] REG_MASK = {
    8'hFF, 8'hFF, 8'h0F, 8'hFF, 8'hFF, 8'h1F, 8'h1F, 8'h1F,
    8'hFF, 8'h1F, 8'h0F, 8'hFF, 8'h0F, 8'hFF, 8'h0F, 8'hFF
  };

  function automatic logic [7:0] mask_value(input logic [3:0] addr,
                                            input logic [7:0] value);
    return value & REG_MASK[addr];
  endfunction

endpackage

// File: rtl/ym_psg_sync.sv
// N-stage flop synchronizer for asynchronous bus inputs.
module ym_psg_sync #(
  parameter int unsigned STAGES = 2,
  parameter int unsigned WIDTH  = 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [STAGES-1:0][WIDTH-1:0] r_pipe;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pipe <= '0;
    end else begin
      r_pipe <= {r_pipe[STAGES-2:0], i_d};
    end
  end

  assign o_q = r_pipe[STAGES-1];

endmodule

// File: rtl/ym_psg_bus_responder.sv
// bc1/bdir bus endpoint emulating two YM2149 register files (TurboSound),
// with glitch-filtered bus cycles, write stream and read-back.
module ym_psg_bus_responder
  import ym_psg_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned MIN_ACTIVE  = 2
) (
  input  logic       cpu_clock,
  input  logic       reset,
  input  logic       bc1,
  input  logic       bdir,
  input  logic [7:0] data_in,
  output logic [7:0] data_out,
  output logic       data_oe,
  output logic       cur_chip,
  output logic [3:0] cur_addr,
  output logic       wr_strobe,
  output logic       wr_chip,
  output logic [3:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       env_restart
);

  localparam logic [3:0] MIN_A = 4'(MIN_ACTIVE);

  logic       w_bc1;
  logic       w_bdir;
  logic [7:0] w_data;
  bus_mode_e  w_mode;

  ym_psg_sync #(.STAGES(SYNC_STAGES), .WIDTH(1)) u_sync_bc1 (
    .i_clk(cpu_clock), .i_rst_n(reset), .i_d(bc1), .o_q(w_bc1)
  );
  ym_psg_sync #(.STAGES(SYNC_STAGES), .WIDTH(1)) u_sync_bdir (
    .i_clk(cpu_clock), .i_rst_n(reset), .i_d(bdir), .o_q(w_bdir)
  );
  ym_psg_sync #(.STAGES(SYNC_STAGES), .WIDTH(8)) u_sync_data (
    .i_clk(cpu_clock), .i_rst_n(reset), .i_d(data_in), .o_q(w_data)
  );

  assign w_mode = bus_mode_e'({w_bdir, w_bc1});

  bus_state_e r_state, nxt_state;
  bus_mode_e  r_mode, nxt_mode;
  logic [3:0] r_cnt, nxt_cnt;
  logic [3:0] w_cnt_inc;
  logic       w_commit;

  logic [7:0] r_hold;
  logic [7:0] r_regs [2][16];
  logic [3:0] r_addr [2];
  logic       r_chip;
  logic       r_wr_strobe;
  logic       r_wr_chip;
  logic [3:0] r_wr_addr;
  logic [7:0] r_wr_data;
  logic       r_env;
  logic       r_oe;
  logic [7:0] r_dout;

  logic [3:0] w_sel_addr;
  logic [3:0] w_wr_addr;
  logic [7:0] w_wr_val;

  assign w_cnt_inc  = r_cnt + 4'd1;
  assign w_sel_addr = r_addr[r_chip];
  assign w_wr_addr  = r_addr[r_chip];
  assign w_wr_val   = mask_value(w_wr_addr, r_hold);

  always_ff @(posedge cpu_clock or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_mode  <= MODE_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= nxt_state;
      r_mode  <= nxt_mode;
      r_cnt   <= nxt_cnt;
    end
  end

  // A mode change while armed or active restarts the filter for the new mode;
  // with MIN_ACTIVE of 1 the first synchronized cycle already qualifies.
  always_comb begin
    nxt_state = r_state;
    nxt_mode  = r_mode;
    nxt_cnt   = r_cnt;
    w_commit  = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (w_mode != MODE_IDLE) begin
          nxt_mode  = w_mode;
          nxt_cnt   = 4'd1;
          nxt_state = (MIN_A <= 4'd1) ? ST_ACTIVE : ST_ARMING;
        end
      end
      ST_ARMING: begin
        if (w_mode == MODE_IDLE) begin
          nxt_state = ST_IDLE;
        end else if (w_mode == r_mode) begin
          nxt_cnt = w_cnt_inc;
          if (w_cnt_inc >= MIN_A) nxt_state = ST_ACTIVE;
        end else begin
          nxt_mode  = w_mode;
          nxt_cnt   = 4'd1;
          nxt_state = (MIN_A <= 4'd1) ? ST_ACTIVE : ST_ARMING;
        end
      end
      ST_ACTIVE: begin
        if (w_mode == MODE_IDLE) begin
          w_commit  = 1'b1;
          nxt_state = ST_IDLE;
        end else if (w_mode != r_mode) begin
          nxt_mode  = w_mode;
          nxt_cnt   = 4'd1;
          nxt_state = (MIN_A <= 4'd1) ? ST_ACTIVE : ST_ARMING;
        end
      end
      default: nxt_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge cpu_clock or negedge reset) begin
    if (!reset) begin
      r_hold      <= '0;
      r_chip      <= 1'b0;
      r_addr[0]   <= '0;
      r_addr[1]   <= '0;
      r_wr_strobe <= 1'b0;
      r_wr_chip   <= 1'b0;
      r_wr_addr   <= '0;
      r_wr_data   <= '0;
      r_env       <= 1'b0;
      r_oe        <= 1'b0;
      r_dout      <= '0;
    end else begin
      r_wr_strobe <= 1'b0;
      r_env       <= 1'b0;
      if (w_mode != MODE_IDLE) r_hold <= w_data;
      r_oe   <= (nxt_state == ST_ACTIVE) && (nxt_mode == MODE_READ);
      r_dout <= mask_value(w_sel_addr, r_regs[r_chip][w_sel_addr]);
      if (w_commit) begin
        if (r_mode == MODE_LATCH) begin
          if (r_hold[7:3] == TS_SELECT) begin
            r_chip <= r_hold[0];
          end else if (r_hold[7:4] == 4'h0) begin
            r_addr[r_chip] <= r_hold[3:0];
          end
        end else if (r_mode == MODE_WRITE) begin
          r_wr_strobe <= 1'b1;
          r_wr_chip   <= r_chip;
          r_wr_addr   <= w_wr_addr;
          r_wr_data   <= w_wr_val;
          r_env       <= (w_wr_addr == ENV_SHAPE_REG);
        end
      end
    end
  end

  always_ff @(posedge cpu_clock or negedge reset) begin
    if (!reset) begin
      for (int unsigned c = 0; c < 2; c++) begin
        for (int unsigned a = 0; a < 16; a++) begin
          r_regs[c][a] <= '0;
        end
      end
    end else if (w_commit && (r_mode == MODE_WRITE)) begin
      r_regs[r_chip][w_wr_addr] <= w_wr_val;
    end
  end

  assign data_out    = r_dout;
  assign data_oe     = r_oe;
  assign cur_chip    = r_chip;
  assign cur_addr    = r_addr[r_chip];
  assign wr_strobe   = r_wr_strobe;
  assign wr_chip     = r_wr_chip;
  assign wr_addr     = r_wr_addr;
  assign wr_data     = r_wr_data;
  assign env_restart = r_env;

endmodule

// File: doc/ym_psg_bus_responder.md
Name: ym_psg_bus_responder

Overview:
- PSG-side end of the bc1/bdir bus that the board decoder drives.
- Emulates the register interface of two YM2149/AY-3-8910 chips in TurboSound arrangement:
  - address latch, register write and register read;
  - chip-select latch command (data[7:3]=11111 during LATCH).
- Feeds a per-chip write stream to downstream tone/noise/envelope generators and drives read-back data onto the CPU data bus.
- Runs on the CPU clock; samples the asynchronous bus signals through synchronizers.

Parameters:
- SYNC_STAGES, 2, flop stages on bc1, bdir, data_in (min 2).
- MIN_ACTIVE, 2, consecutive synchronized cycles a non-idle mode must hold before it counts as a valid bus cycle (glitch filter, 1..15).

Ports:
- cpu_clock  in  1  system clock; all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- bc1  in  1  bus control, asynchronous.
- bdir  in  1  bus direction, asynchronous.
- data_in  in  8  CPU data bus, asynchronous.
- data_out  out  8  read-back register value.
- data_oe  out  1  high while data_out should drive the bus.
- cur_chip  out  1  currently selected chip (0/1).
- cur_addr  out  4  latched register address of the selected chip.
- wr_strobe  out  1  one-cycle pulse on each committed register write.
- wr_chip  out  1  chip of the committed write.
- wr_addr  out  4  register index of the committed write.
- wr_data  out  8  masked value of the committed write.
- env_restart  out  1  one-cycle pulse on a write to R13 (same cycle as wr_strobe).

Behaviour:
- Reset (reset=0, async):
  - Clears both 16x8 register files, both address latches, cur_chip, synchronizers, filter counter and FSM.
  - All outputs 0, data_oe=0.
- Mode decode of synchronized {bdir,bc1}:
  - 00 IDLE, 01 READ, 10 WRITE, 11 LATCH.
- FSM states:
  - IDLE → ARMING on non-IDLE mode; the filter counter loads 1.
  - ARMING:
    - same mode: counter increments; at MIN_ACTIVE → ACTIVE(mode).
    - IDLE: → IDLE, nothing committed (glitch).
    - other non-IDLE mode: restart ARMING with counter=1.
  - ACTIVE(WRITE/LATCH):
    - hold register captures synchronized data_in every cycle.
    - mode→IDLE: commit, then → IDLE.
    - mode→other non-IDLE: abort without commit, → ARMING.
  - ACTIVE(READ):
    - data_oe=1 from the cycle of entry (registered) until the cycle after the mode leaves READ.
    - data_out = masked regs[cur_chip][cur_addr], refreshed every cycle.
- Commit:
  - LATCH with hold[7:3]=11111: cur_chip ← hold[0]; address latches unchanged.
  - LATCH with hold[7:4]=0000: addr[cur_chip] ← hold[3:0].
  - Any other LATCH value: ignored (address deselected; subsequent WRITE still uses the existing latch).
  - WRITE: regs[cur_chip][addr[cur_chip]] ← masked hold. wr_strobe, wr_chip, wr_addr, wr_data are registered in the same cycle as the commit, so they are visible the next cycle. wr_* hold their value until the next commit.
- Width masks, applied on write and on read:
  - R1, R3, R5, R13 → 4 bits.
  - R6, R8, R9, R10 → 5 bits.
  - All others → 8 bits.
- env_restart pulses on any write to R13, even when the value is unchanged.
- Latency from raw bus edge to wr_strobe: SYNC_STAGES+1 cycles after bc1/bdir return to 00.
- Reset mid-cycle: a pending commit is discarded.
- Chip switch during READ: the switch requires a LATCH, so it cannot occur mid-READ.

Decomposition:
- Shared package ym_psg_pkg:
  - mode encodings (IDLE/READ/WRITE/LATCH);
  - FSM state enum;
  - TS select pattern 5'b11111;
  - per-register mask constant array;
  - R13 index constant.
- One natural sub-module: ym_psg_sync, an N-stage synchronizer instantiated for bc1, bdir and the 8-bit data_in.

Test Plan:
- Reset, then LATCH 0x07, WRITE 0x38 (each held 8 cycles) → wr_strobe one pulse, wr_chip=0, wr_addr=7, wr_data=0x38; READ → data_oe=1, data_out=0x38.
- LATCH 0x01, WRITE 0xFF → wr_data=0x0F; LATCH 0x08, WRITE 0xFF → 0x1F; LATCH 0x0D, WRITE 0x0A → env_restart=1 together with wr_strobe.
- LATCH 0xFF → cur_chip=1, cur_addr=0; LATCH 0x03, WRITE 0x05 → wr_chip=1. LATCH 0xFE, then read R3 → chip0 value 0x00; select chip1 → read R3 = 0x05.
- bdir/bc1 pulse shorter than MIN_ACTIVE synchronized cycles (WRITE, 1 cycle) → no wr_strobe, register unchanged. Direct WRITE→LATCH transition → WRITE aborted, LATCH committed.
- LATCH 0x25 → ignored; cur_addr stays at its previous value.
- Assert reset during an active WRITE → no wr_strobe; all registers read 0 and cur_chip=0 after release.
